testbus_arbiter: RTL

- Shares the board's single 8-bit FPGA test bus and status LED among NUM_REQ internal debug sources.
- Uses a round-robin request/grant handshake with a guaranteed minimum tenure per grant.
- Registers the granted source's test data onto ov_FPGA_TEST and drives o_LED to show bus activity or current owner.
- Sits at top level between the debug sources and the test-header and LED pins.

---
 rtl/testbus_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/testbus_arbiter.sv
// testbus_arbiter: round-robin owner of the shared 8-bit FPGA test bus and status LED, minimum tenure HOLD_CYCLES.
// Latency: grant 1 cycle after request; owner data on ov_FPGA_TEST 1 cycle after grant; 1-cycle RELEASE gap between owners.
// Backpressure: none; requests are level-held until granted. Optional TESTBUS_ARB_LED_BLINK_EN blinks the owner index on o_LED.
module testbus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int LED_DIV_W   = 24
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_n,
    input  logic [NUM_REQ-1:0]   iv_REQ,
    input  logic [8*NUM_REQ-1:0] iv_TEST_DATA,
    output logic [NUM_REQ-1:0]   ov_GNT,
    output logic [7:0]           ov_FPGA_TEST,
    output logic                 o_LED,
    output logic                 o_BUSY
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || LED_DIV_W < 1) begin : g_bad_param
        $error("testbus_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_q;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic [CW-1:0] hold_q;
    logic          owner_req;
    logic          other_req;
    int            cand;

    // Search upward from the source after the last owner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_vld && iv_REQ[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    assign owner_req = |(iv_REQ & ov_GNT);
    assign other_req = |(iv_REQ & ~ov_GNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = GRANT;
            GRANT:   if (!owner_req || (hold_q == '0 && other_req)) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= IW'(NUM_REQ - 1);
            hold_q       <= '0;
            ov_GNT       <= '0;
            ov_FPGA_TEST <= 8'h00;
            o_BUSY       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    ov_FPGA_TEST <= 8'h00;
                    if (win_vld) begin
                        ov_GNT  <= NUM_REQ'(1) << win_idx;
                        owner_q <= win_idx;
                        o_BUSY  <= 1'b1;
                        hold_q  <= CW'(HOLD_CYCLES - 1);
                    end
                end
                GRANT: begin
                    if (state_d == RELEASE) begin
                        ov_GNT       <= '0;
                        ov_FPGA_TEST <= 8'h00;
                        o_BUSY       <= 1'b0;
                        last_q       <= owner_q;
                    end else begin
                        ov_FPGA_TEST <= iv_TEST_DATA[{owner_q, 3'b000} +: 8];
                        if (hold_q != '0) hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    ov_GNT       <= '0;
                    ov_FPGA_TEST <= 8'h00;
                    o_BUSY       <= 1'b0;
                end
            endcase
        end
    end

`ifdef TESTBUS_ARB_LED_BLINK_EN
    localparam int FRAME_TICKS = 2 * (NUM_REQ + 1);
    localparam int FW          = $clog2(FRAME_TICKS);

    logic [LED_DIV_W-1:0] presc_q;
    logic [FW-1:0]        tick_q;
    logic [FW-1:0]        pulse_end;

    // owner+1 pulses of one tick high, one tick low, at the start of each frame.
    assign pulse_end = FW'(owner_q) + FW'(owner_q) + FW'(2);

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else if (state_q == GRANT) begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) tick_q <= (tick_q == FW'(FRAME_TICKS - 1)) ? '0 : tick_q + 1'b1;
        end else begin
            presc_q <= '0;
            tick_q  <= '0;
        end
    end

    assign o_LED = (state_q == GRANT) && (tick_q < pulse_end) && !tick_q[0];
`else
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) o_LED <= 1'b0;
        else            o_LED <= (state_q == GRANT);
    end
`endif

endmodule
